// File: rtl/resp_suppress_pkg.sv
// Shared types and helpers for the multi-channel response-suppression stage.
package resp_suppress_pkg;

  typedef enum logic [1:0] {
    PASS,
    LATENT,
    DRAIN
  } state_e;

  // Outstanding and stale-response counters must hold 0..max_out inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_out);
    return (max_out < 1) ? 1 : $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/resp_suppress_ch.sv
// One channel: outstanding tracking, setback FSM, latent-request replay and stale-response drop.
module resp_suppress_ch
  import resp_suppress_pkg::*;
#(
  parameter int unsigned MaxOutstanding  = 4,
  parameter int unsigned AW              = 32,
  parameter int unsigned DW              = 32,
  parameter bit          BlockUntilEmpty = 1'b0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            setback_i,
  input  logic            bus_hold_i,
  output logic            resp_ok_o,
  output logic            drop_pending_o,
  input  logic            req_i,
  input  logic            we_i,
  input  logic [AW-1:0]   addr_i,
  input  logic [DW-1:0]   data_i,
  input  logic [DW/8-1:0] be_i,
  output logic            gnt_o,
  output logic            r_valid_o,
  output logic            req_o,
  output logic            we_o,
  output logic [AW-1:0]   addr_o,
  output logic [DW-1:0]   data_o,
  output logic [DW/8-1:0] be_o,
  input  logic            gnt_i,
  input  logic            r_valid_i
);

  localparam int unsigned CW = cnt_width(MaxOutstanding);

  typedef struct packed {
    logic            we;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   data;
    logic [DW/8-1:0] be;
  } payload_t;

  state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, drop_q, drop_d;
  logic     latent_q, latent_d;
  payload_t pl_q, pl_d, in_pl, out_pl;
  logic     full, granted, rsp, stale;

  always_comb begin
    in_pl   = '{we: we_i, addr: addr_i, data: data_i, be: be_i};
    full    = (cnt_q == CW'(MaxOutstanding)) && !r_valid_i;
    if (state_q == LATENT) begin
      req_o  = 1'b1;
      out_pl = pl_q;
    end else begin
      req_o  = (req_i & ~bus_hold_i & ~full) | latent_q;
      out_pl = in_pl;
    end
    gnt_o   = gnt_i & ~full & (state_q != LATENT) &
              ~(BlockUntilEmpty && (state_q == DRAIN));
    granted = req_o & gnt_i;
    rsp     = r_valid_i && (cnt_q != '0);
    cnt_d   = cnt_q + CW'(granted) - CW'(rsp);
    // Stale responses are always the oldest ones, so drop>0 means this one is stale.
    stale     = r_valid_i && (drop_q != '0);
    r_valid_o = r_valid_i & ~stale & ~setback_i;
    latent_d  = req_o & ~gnt_i;

    state_d = state_q;
    drop_d  = drop_q;
    pl_d    = pl_q;
    unique case (state_q)
      PASS: begin
        if (setback_i) begin
          drop_d = cnt_d;
          if (req_o && !gnt_i) begin
            state_d = LATENT;
            pl_d    = out_pl;
          end else if (cnt_d != '0) begin
            state_d = DRAIN;
          end
        end
      end
      LATENT: begin
        // The replayed grant belongs to the pre-setback core, so it is stale too.
        drop_d = drop_q + CW'(gnt_i) - CW'(stale);
        if (setback_i) drop_d = cnt_d;
        if (gnt_i) state_d = DRAIN;
      end
      DRAIN: begin
        drop_d = drop_q - CW'(stale);
        if (setback_i) drop_d = cnt_d;
        if (drop_d == '0) state_d = PASS;
      end
      default: state_d = PASS;
    endcase
  end

  assign we_o   = out_pl.we;
  assign addr_o = out_pl.addr;
  assign data_o = out_pl.data;
  assign be_o   = out_pl.be;

  assign resp_ok_o      = (cnt_q == '0) && !latent_q && (state_q == PASS);
  assign drop_pending_o = (drop_q != '0) || (state_q == LATENT);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= PASS;
      cnt_q    <= '0;
      drop_q   <= '0;
      latent_q <= 1'b0;
      pl_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
      latent_q <= latent_d;
      pl_q     <= pl_d;
    end
  end

endmodule

// File: rtl/resp_suppress_mc.sv
// Multi-channel response-suppression stage: independent per-channel instances.
module resp_suppress_mc
  import resp_suppress_pkg::*;
#(
  parameter int unsigned NumChannels     = 3,
  parameter int unsigned MaxOutstanding  = 4,
  parameter int unsigned AW              = 32,
  parameter int unsigned DW              = 32,
  parameter bit          BlockUntilEmpty = 1'b0
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NumChannels-1:0]              setback_i,
  input  logic [NumChannels-1:0]              bus_hold_i,
  output logic [NumChannels-1:0]              resp_ok_o,
  output logic [NumChannels-1:0]              drop_pending_o,
  input  logic [NumChannels-1:0]              req_i,
  input  logic [NumChannels-1:0]              we_i,
  input  logic [NumChannels-1:0][AW-1:0]      addr_i,
  input  logic [NumChannels-1:0][DW-1:0]      data_i,
  input  logic [NumChannels-1:0][DW/8-1:0]    be_i,
  output logic [NumChannels-1:0]              gnt_o,
  output logic [NumChannels-1:0]              r_valid_o,
  output logic [NumChannels-1:0]              req_o,
  output logic [NumChannels-1:0]              we_o,
  output logic [NumChannels-1:0][AW-1:0]      addr_o,
  output logic [NumChannels-1:0][DW-1:0]      data_o,
  output logic [NumChannels-1:0][DW/8-1:0]    be_o,
  input  logic [NumChannels-1:0]              gnt_i,
  input  logic [NumChannels-1:0]              r_valid_i
);

  for (genvar c = 0; c < NumChannels; c++) begin : g_ch
    resp_suppress_ch #(
      .MaxOutstanding  (MaxOutstanding),
      .AW              (AW),
      .DW              (DW),
      .BlockUntilEmpty (BlockUntilEmpty)
    ) u_ch (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .setback_i      (setback_i[c]),
      .bus_hold_i     (bus_hold_i[c]),
      .resp_ok_o      (resp_ok_o[c]),
      .drop_pending_o (drop_pending_o[c]),
      .req_i          (req_i[c]),
      .we_i           (we_i[c]),
      .addr_i         (addr_i[c]),
      .data_i         (data_i[c]),
      .be_i           (be_i[c]),
      .gnt_o          (gnt_o[c]),
      .r_valid_o      (r_valid_o[c]),
      .req_o          (req_o[c]),
      .we_o           (we_o[c]),
      .addr_o         (addr_o[c]),
      .data_o         (data_o[c]),
      .be_o           (be_o[c]),
      .gnt_i          (gnt_i[c]),
      .r_valid_i      (r_valid_i[c])
    );
  end

endmodule
